cnn_layer_sequencer: RTL and testbench

CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

---
 rtl/cnn_layer_sequencer_pkg.sv | 19 +
 rtl/cnn_layer_sequencer_xy_counter.sv | 52 +++++
 rtl/cnn_layer_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared constants and state encoding for the CNN layer sequencer.
package cnn_layer_sequencer_pkg;

  localparam int CONV_DIM   = 24;
  localparam int POOL_DIM   = 12;
  localparam int RELU_DEPTH = 576;
  localparam int POOL_DEPTH = 144;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_DRAIN,
    ST_POOL,
    ST_PDRAIN,
    ST_FC_WAIT,
    ST_FINISH
  } seq_state_e;

endpackage

// File: rtl/cnn_layer_sequencer_xy_counter.sv
// Row-major 2-D coordinate counter: y runs fastest, x advances when y wraps.
module seq_xy_counter #(
  parameter int DIM = 24,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         last
);

  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic         x_end, y_end;

  assign x_end = (x_q == W'(DIM - 1));
  assign y_end = (y_q == W'(DIM - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (y_end) begin
        y_d = '0;
        x_d = x_end ? '0 : x_q + 1'b1;
      end else begin
        y_d = y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end && y_end;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences one CNN inference: conv window scan, ReLU writeback, pooling scan,
// FC handshake with timeout, and completion strobes.
module cnn_layer_sequencer
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int CONV_LAT   = 2,
  parameter int POOL_LAT   = 1,
  parameter int FC_TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       fc_done,
  output logic       busy,
  output logic       conv_valid,
  output logic [4:0] conv_x,
  output logic [4:0] conv_y,
  output logic       relu_wr_en,
  output logic [9:0] relu_wr_addr,
  output logic       pool_valid,
  output logic [3:0] pool_x,
  output logic [3:0] pool_y,
  output logic       pool_out_valid,
  output logic       fc_start,
  output logic       result_latch,
  output logic       done,
  output logic       error
);

  localparam int ADDR_W = $clog2(RELU_DEPTH);
  localparam int CNT_W  = $clog2(FC_TIMEOUT + CONV_LAT + POOL_LAT + 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              error_q, error_d;

  logic [4:0]        cx_raw, cy_raw;
  logic [3:0]        px_raw, py_raw;
  logic              conv_last, pool_last;
  logic              conv_en, pool_en;

  logic [ADDR_W-1:0] relu_addr_in;
  logic [CONV_LAT-1:0] relu_vld_q, relu_vld_d;
  logic [ADDR_W-1:0] relu_addr_q [CONV_LAT];
  logic [ADDR_W-1:0] relu_addr_d [CONV_LAT];
  logic [POOL_LAT-1:0] pool_vld_q, pool_vld_d;

  assign conv_en = (state_q == ST_CONV);
  assign pool_en = (state_q == ST_POOL);

  seq_xy_counter #(.DIM(CONV_DIM), .W(5)) u_conv_xy (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .en   (conv_en),
    .x    (cx_raw),
    .y    (cy_raw),
    .last (conv_last)
  );

  seq_xy_counter #(.DIM(POOL_DIM), .W(4)) u_pool_xy (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .en   (pool_en),
    .x    (px_raw),
    .y    (py_raw),
    .last (pool_last)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    error_d      = error_q;
    fc_start     = 1'b0;
    done         = 1'b0;
    result_latch = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CONV;
          error_d = 1'b0;
        end
      end
      ST_CONV: begin
        if (conv_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(CONV_LAT - 1)) state_d = ST_POOL;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_POOL: begin
        if (pool_last) state_d = ST_PDRAIN;
      end
      ST_PDRAIN: begin
        if (cnt_q == CNT_W'(POOL_LAT - 1)) begin
          state_d  = ST_FC_WAIT;
          fc_start = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FC_WAIT: begin
        // fc_done is only looked at here, so a pulse alongside fc_start is ignored
        if (fc_done) begin
          state_d = ST_FINISH;
        end else if (cnt_q == CNT_W'(FC_TIMEOUT - 1)) begin
          state_d = ST_FINISH;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FINISH: begin
        state_d      = ST_IDLE;
        done         = 1'b1;
        result_latch = !error_q;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      error_d      = error_q;
      fc_start     = 1'b0;
      done         = 1'b0;
      result_latch = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign relu_addr_in = ADDR_W'(cx_raw) * ADDR_W'(CONV_DIM) + ADDR_W'(cy_raw);

  always_comb begin
    relu_vld_d     = '0;
    pool_vld_d     = '0;
    relu_addr_d[0] = relu_addr_in;
    for (int i = 1; i < CONV_LAT; i++) relu_addr_d[i] = relu_addr_q[i-1];
    if (!abort) begin
      relu_vld_d[0] = conv_en;
      for (int i = 1; i < CONV_LAT; i++) relu_vld_d[i] = relu_vld_q[i-1];
      pool_vld_d[0] = pool_en;
      for (int i = 1; i < POOL_LAT; i++) pool_vld_d[i] = pool_vld_q[i-1];
    end
  end

  // delay-line stage boundary: valids are control and flush, addresses are data
  always_ff @(posedge clk) begin
    if (rst) begin
      relu_vld_q <= '0;
      pool_vld_q <= '0;
    end else begin
      relu_vld_q <= relu_vld_d;
      pool_vld_q <= pool_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CONV_LAT; i++) relu_addr_q[i] <= relu_addr_d[i];
  end

  assign busy           = (state_q != ST_IDLE);
  assign conv_valid     = conv_en;
  assign conv_x         = conv_en ? cx_raw : '0;
  assign conv_y         = conv_en ? cy_raw : '0;
  assign relu_wr_en     = relu_vld_q[CONV_LAT-1];
  assign relu_wr_addr   = relu_wr_en ? relu_addr_q[CONV_LAT-1] : '0;
  assign pool_valid     = pool_en;
  assign pool_x         = pool_en ? px_raw : '0;
  assign pool_y         = pool_en ? py_raw : '0;
  assign pool_out_valid = pool_vld_q[POOL_LAT-1];
  assign error          = error_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Cycle-accurate bench: expected outputs are derived from the run timeline
// (cycle index since start acceptance) with plain arithmetic.
module tb_cnn_layer_sequencer;

  localparam int CL = 2;
  localparam int PL = 1;
  localparam int FT = 15;
  localparam int KS = 576 + CL + 144 + PL;

  logic       clk = 1'b0;
  logic       rst, start, abort, fc_done;
  logic       busy, conv_valid, relu_wr_en, pool_valid, pool_out_valid;
  logic       fc_start, result_latch, done, error;
  logic [4:0] conv_x, conv_y;
  logic [9:0] relu_wr_addr;
  logic [3:0] pool_x, pool_y;

  cnn_layer_sequencer #(.CONV_LAT(CL), .POOL_LAT(PL), .FC_TIMEOUT(FT)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .fc_done        (fc_done),
    .busy           (busy),
    .conv_valid     (conv_valid),
    .conv_x         (conv_x),
    .conv_y         (conv_y),
    .relu_wr_en     (relu_wr_en),
    .relu_wr_addr   (relu_wr_addr),
    .pool_valid     (pool_valid),
    .pool_x         (pool_x),
    .pool_y         (pool_y),
    .pool_out_valid (pool_out_valid),
    .fc_start       (fc_start),
    .result_latch   (result_latch),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit active = 0, err_m = 0, go_req = 0, noise = 0, hold_rst = 0;
  int k = 0, nfc_cur = 0, nfc_next = 0, abort_k = 0, rst_k = 0;
  int relu_cnt = 0, pool_cnt = 0, rl_cnt = 0, done_cnt = 0, done_k = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fin_k();
    return KS + ((nfc_cur == 0) ? FT : nfc_cur) + 1;
  endfunction

  function automatic logic [63:0] model_out();
    logic       b, cv, rw, pv, pov, fs, rl, dn, er;
    logic [4:0] cx, cy;
    logic [9:0] ra;
    logic [3:0] px, py;
    int         f;
    {b, cv, rw, pv, pov, fs, rl, dn} = '0;
    cx = '0; cy = '0; ra = '0; px = '0; py = '0;
    er = err_m;
    if (active) begin
      f  = fin_k();
      b  = 1'b1;
      er = (nfc_cur == 0) && (k == f);
      if (k >= 1 && k <= 576) begin
        cv = 1'b1; cx = 5'((k - 1) / 24); cy = 5'((k - 1) % 24);
      end
      if (k >= 1 + CL && k <= 576 + CL) begin
        rw = 1'b1; ra = 10'(k - 1 - CL);
      end
      if (k >= 577 + CL && k <= 720 + CL) begin
        pv = 1'b1; px = 4'((k - 577 - CL) / 12); py = 4'((k - 577 - CL) % 12);
      end
      pov = (k >= 577 + CL + PL) && (k <= 720 + CL + PL);
      fs  = (k == KS);
      dn  = (k == f);
      rl  = dn && (nfc_cur != 0);
    end
    return {27'd0, b, cv, cx, cy, rw, ra, pv, px, py, pov, fs, rl, dn, er};
  endfunction

  task automatic cycle();
    logic [63:0] got;
    @(posedge clk);
    #1;
    if (rst) begin
      active = 0; err_m = 0; rst_k = 0;
    end else if (active && abort) begin
      check_eq("abort_no_done", 64'(done_cnt), 64'd0);
      active = 0; abort_k = 0;
    end else if (active) begin
      k++;
      if (k > fin_k()) begin
        check_eq("relu_writes", 64'(relu_cnt), 64'd576);
        check_eq("pool_valids", 64'(pool_cnt), 64'd144);
        check_eq("result_latch_cnt", 64'(rl_cnt), (nfc_cur != 0) ? 64'd1 : 64'd0);
        check_eq("done_cnt", 64'(done_cnt), 64'd1);
        check_eq("latency", 64'(done_k + 1),
                 64'(1 + 576 + CL + 144 + PL + ((nfc_cur == 0) ? FT : nfc_cur) + 1));
        active = 0;
        err_m  = (nfc_cur == 0);
      end
    end else if (start) begin
      active = 1; k = 1; err_m = 0; nfc_cur = nfc_next; go_req = 0;
      relu_cnt = 0; pool_cnt = 0; rl_cnt = 0; done_cnt = 0; done_k = 0;
    end
    start   = (!active && go_req) || (active && noise && $urandom_range(0, 31) == 0);
    abort   = active && (abort_k != 0) && (k == abort_k);
    rst     = hold_rst || (active && (rst_k != 0) && (k == rst_k));
    fc_done = active && (((nfc_cur != 0) && (k == KS + nfc_cur)) ||
                         (noise && (k <= KS) && ($urandom_range(0, 7) == 0 || k == KS)));
    @(negedge clk);
    got = {27'd0, busy, conv_valid, conv_x, conv_y, relu_wr_en, relu_wr_addr, pool_valid,
           pool_x, pool_y, pool_out_valid, fc_start, result_latch, done, error};
    check_eq($sformatf("outputs k=%0d active=%0d", k, active), got, model_out());
    if (relu_wr_en) relu_cnt++;
    if (pool_valid) pool_cnt++;
    if (result_latch) rl_cnt++;
    if (done) begin
      done_cnt++;
      done_k = k;
    end
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 3000 && (go_req || active); i++) cycle();
    if (go_req || active) check_eq("run_bound", 64'(active || go_req), 64'd0);
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 3000 && go_req; i++) cycle();
    if (go_req) check_eq("accept_bound", 64'(go_req), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; fc_done = 1'b0;
    hold_rst = 1;
    repeat (3) cycle();
    hold_rst = 0;
    repeat (4) cycle();

    nfc_next = 10; go_req = 1;
    run_to_idle();
    repeat (2) cycle();

    noise = 1;
    nfc_next = $urandom_range(1, FT - 1); go_req = 1;
    wait_accept();
    nfc_next = $urandom_range(1, FT - 1); go_req = 1;
    run_to_idle();
    noise = 0;
    repeat (2) cycle();

    abort_k = 301; nfc_next = 10; go_req = 1;
    run_to_idle();
    repeat (5) cycle();

    nfc_next = 0; go_req = 1;
    run_to_idle();
    repeat (5) cycle();
    nfc_next = $urandom_range(1, FT - 1); go_req = 1;
    run_to_idle();
    repeat (2) cycle();

    rst_k = 577 + CL + 50; nfc_next = 5; go_req = 1;
    run_to_idle();
    repeat (3) cycle();
    nfc_next = 10; go_req = 1;
    run_to_idle();
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
